dev_info_arbiter: RTL and testbench

DEV_INFO_ARBITER -- requirements
Module: dev_info_arbiter

---
 rtl/dev_info_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dev_info_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dev_info_arbiter.sv
// ---------------------------------------------------------------------------
// dev_info_arbiter
//
// Shares one device-info register slave between two read-only requesters:
// requester 0 (host CPU) and requester 1 (MKIO terminal). Only one read is
// ever outstanding. Ties are broken round-robin, and r0 wins the first tie
// after reset.
//
// Optional feature macro: DEV_INFO_ARB_TIMEOUT_EN
//   When defined, a read that waits TIMEOUT_CYCLES cycles without slave data
//   is aborted. The winner then receives 32'hDEAD_0000 | address, and
//   err_timeout pulses for one cycle. When undefined, the arbiter waits for
//   the slave indefinitely and err_timeout is tied low.
//
// Ports
//   clk, reset                  clock (rising edge), async active-high reset
//   rN_address [2:0]            register index from requester N
//   rN_read                     read request, held until accepted
//   rN_waitrequest              low for the single accept cycle
//   rN_readdata [31:0]          last data returned to requester N
//   rN_readdatavalid            one-cycle data strobe to requester N
//   m_address [2:0], m_read     request to the device-info slave
//   m_readdata [31:0]           data from the slave
//   m_readdatavalid             data strobe from the slave
//   err_timeout                 one-cycle pulse when a read is aborted
// ---------------------------------------------------------------------------
module dev_info_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  r0_address,
   input  logic        r0_read,
   output logic        r0_waitrequest,
   output logic [31:0] r0_readdata,
   output logic        r0_readdatavalid,
   input  logic [2:0]  r1_address,
   input  logic        r1_read,
   output logic        r1_waitrequest,
   output logic [31:0] r1_readdata,
   output logic        r1_readdatavalid,
   output logic [2:0]  m_address,
   output logic        m_read,
   input  logic [31:0] m_readdata,
   input  logic        m_readdatavalid,
   output logic        err_timeout
);

   // Catch an out-of-range timeout at elaboration, because the counter is
   // only 8 bits wide.
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cfg
      $error("dev_info_arbiter: TIMEOUT_CYCLES must be in 2..255");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        grant_q;        // requester that owns the current transaction
   logic        last_grant_q;   // requester granted most recently
   logic [2:0]  addr_q;         // address latched at grant
   logic        latch_en;
   logic        win_d;
   logic        rsp_en;
   logic [31:0] rsp_data;

`ifdef DEV_INFO_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_cnt_q;
   logic       tmo_hit;
   logic       err_q;
`endif

   // --- state register ---
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // --- next-state, arbitration and response selection ---
   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      win_d    = last_grant_q;
      rsp_en   = 1'b0;
      rsp_data = m_readdata;
`ifdef DEV_INFO_ARB_TIMEOUT_EN
      tmo_hit  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (r0_read || r1_read) begin
               latch_en = 1'b1;
               state_d  = ISSUE;
               // On a tie, grant the requester that did not win last time.
               if (r0_read && r1_read) win_d = ~last_grant_q;
               else                    win_d = r1_read;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            // Slave data takes priority over a timeout in the same cycle.
            if (m_readdatavalid) begin
               rsp_en  = 1'b1;
               state_d = IDLE;
            end
`ifdef DEV_INFO_ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               rsp_en   = 1'b1;
               tmo_hit  = 1'b1;
               rsp_data = 32'hDEAD_0000 | {29'd0, addr_q};
               state_d  = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // --- grant, address and response registers ---
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_q          <= 1'b0;
         last_grant_q     <= 1'b1;
         addr_q           <= 3'd0;
         r0_readdata      <= 32'd0;
         r1_readdata      <= 32'd0;
         r0_readdatavalid <= 1'b0;
         r1_readdatavalid <= 1'b0;
      end else begin
         r0_readdatavalid <= 1'b0;
         r1_readdatavalid <= 1'b0;
         if (latch_en) begin
            grant_q      <= win_d;
            last_grant_q <= win_d;
            addr_q       <= win_d ? r1_address : r0_address;
         end
         // Only the owner's data register is written; the other holds.
         if (rsp_en) begin
            if (grant_q) begin
               r1_readdata      <= rsp_data;
               r1_readdatavalid <= 1'b1;
            end else begin
               r0_readdata      <= rsp_data;
               r0_readdatavalid <= 1'b1;
            end
         end
      end
   end

`ifdef DEV_INFO_ARB_TIMEOUT_EN
   // --- timeout counter: cleared while in ISSUE so that it starts at zero
   //     on WAIT entry, then counts the WAIT cycles ---
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q <= 8'd0;
         err_q     <= 1'b0;
      end else begin
         err_q <= tmo_hit;
         if (state_q == ISSUE)     tmo_cnt_q <= 8'd0;
         else if (state_q == WAIT) tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
   end

   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

   // --- outputs decoded from the state ---
   assign m_read         = (state_q == ISSUE);
   assign m_address      = addr_q;
   assign r0_waitrequest = !((state_q == ISSUE) && !grant_q);
   assign r1_waitrequest = !((state_q == ISSUE) &&  grant_q);

endmodule

// File: tb/tb_dev_info_arbiter.sv
module tb_dev_info_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  r0_address, r1_address, m_address;
   logic        r0_read, r1_read;
   logic        r0_waitrequest, r1_waitrequest;
   logic [31:0] r0_readdata, r1_readdata, m_readdata;
   logic        r0_readdatavalid, r1_readdatavalid;
   logic        m_read, m_readdatavalid, err_timeout;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_rd0, exp_rd1;

   dev_info_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .r0_address       (r0_address),
      .r0_read          (r0_read),
      .r0_waitrequest   (r0_waitrequest),
      .r0_readdata      (r0_readdata),
      .r0_readdatavalid (r0_readdatavalid),
      .r1_address       (r1_address),
      .r1_read          (r1_read),
      .r1_waitrequest   (r1_waitrequest),
      .r1_readdata      (r1_readdata),
      .r1_readdatavalid (r1_readdatavalid),
      .m_address        (m_address),
      .m_read           (m_read),
      .m_readdata       (m_readdata),
      .m_readdatavalid  (m_readdatavalid),
      .err_timeout      (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_m_read"}, m_read, 1'b0);
      chk({tag, "_m_address"}, m_address, 3'd0);
      chk({tag, "_r0_wr"}, r0_waitrequest, 1'b1);
      chk({tag, "_r1_wr"}, r1_waitrequest, 1'b1);
      chk({tag, "_r0_rdv"}, r0_readdatavalid, 1'b0);
      chk({tag, "_r1_rdv"}, r1_readdatavalid, 1'b0);
      chk({tag, "_r0_rd"}, r0_readdata, 32'd0);
      chk({tag, "_r1_rd"}, r1_readdata, 32'd0);
      chk({tag, "_err"}, err_timeout, 1'b0);
   endtask

   // Entered just after the edge that moves the arbiter into ISSUE. The
   // slave answers dly cycles after the first WAIT cycle. Returns just after
   // the edge on which the winner's readdatavalid rises.
   task automatic run_txn(input string tag, input logic w, input logic [2:0] a,
                          input logic [31:0] d, input logic drop, input int dly);
      chk({tag, "_issue_m_read"}, m_read, 1'b1);
      chk({tag, "_issue_m_address"}, m_address, a);
      chk({tag, "_issue_r0_wr"}, r0_waitrequest, w);
      chk({tag, "_issue_r1_wr"}, r1_waitrequest, !w);
      if (drop) begin
         if (w) r1_read = 1'b0;
         else   r0_read = 1'b0;
      end
      tick();
      chk({tag, "_wait_m_read"}, m_read, 1'b0);
      chk({tag, "_wait_wr"}, {r0_waitrequest, r1_waitrequest}, 2'b11);
      repeat (dly) tick();
      chk({tag, "_wait_no_rdv"}, {r0_readdatavalid, r1_readdatavalid}, 2'b00);
      chk({tag, "_wait_err"}, err_timeout, 1'b0);
      m_readdatavalid = 1'b1;
      m_readdata      = d;
      tick();
      m_readdatavalid = 1'b0;
      m_readdata      = 32'h0BAD_0BAD;
      if (w) exp_rd1 = d;
      else   exp_rd0 = d;
      chk({tag, "_rdv0"}, r0_readdatavalid, !w);
      chk({tag, "_rdv1"}, r1_readdatavalid, w);
      chk({tag, "_rd0"}, r0_readdata, exp_rd0);
      chk({tag, "_rd1"}, r1_readdata, exp_rd1);
      chk({tag, "_err"}, err_timeout, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset           = 1'b1;
      r0_address      = 3'd0;
      r1_address      = 3'd0;
      r0_read         = 1'b0;
      r1_read         = 1'b0;
      m_readdata      = 32'd0;
      m_readdatavalid = 1'b0;
      exp_rd0         = 32'd0;
      exp_rd1         = 32'd0;
      #2;
      chk_reset("rst_async");
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk_reset("rst_release");

      // Single r0 read of address 0 with a one-cycle slave.
      r0_address = 3'd0;
      r0_read    = 1'b1;
      tick();
      run_txn("r0_single", 1'b0, 3'd0, 32'h4D46_4441, 1'b1, 0);
      tick();
      chk("r0_single_rdv_drop", r0_readdatavalid, 1'b0);
      chk("r0_single_idle", m_read, 1'b0);

      // Reset while WAITing: nothing is delivered, late slave data ignored.
      r0_address = 3'd3;
      r0_read    = 1'b1;
      tick();
      r0_read = 1'b0;
      tick();
      chk("rstwait_in_wait", m_read, 1'b0);
      reset = 1'b1;
      #1;
      chk_reset("rstwait_async");
      exp_rd0 = 32'd0;
      exp_rd1 = 32'd0;
      tick();
      reset           = 1'b0;
      m_readdatavalid = 1'b1;
      m_readdata      = 32'hCAFE_0003;
      tick();
      m_readdatavalid = 1'b0;
      chk_reset("rstwait_late_valid");
      tick();
      chk_reset("rstwait_after");

      // Tie from reset: r0 first, then r1, then r0 again on the next tie.
      r0_address = 3'd4;
      r1_address = 3'd5;
      r0_read    = 1'b1;
      r1_read    = 1'b1;
      tick();
      run_txn("tie_r0", 1'b0, 3'd4, 32'hA000_0004, 1'b1, 0);
      r0_address = 3'd2;
      r0_read    = 1'b1;
      tick();
      run_txn("tie_r1", 1'b1, 3'd5, 32'hB000_0005, 1'b0, 0);
      tick();
      run_txn("tie_r0_again", 1'b0, 3'd2, 32'hC000_0002, 1'b1, 0);

      // r1 alone keeps read high: served every 3 cycles.
      for (int i = 0; i < 3; i++) begin
         r1_address = 3'(5 + i);
         tick();
         run_txn($sformatf("b2b_r1_%0d", i), 1'b1, 3'(5 + i), 32'h1000_0000 + 32'(i),
                 (i == 2), 0);
      end

      // Slave strobe with nothing outstanding is ignored.
      tick();
      m_readdatavalid = 1'b1;
      m_readdata      = 32'h55AA_55AA;
      tick();
      m_readdatavalid = 1'b0;
      tick();
      chk("idle_valid_rdv", {r0_readdatavalid, r1_readdatavalid}, 2'b00);
      chk("idle_valid_rd0", r0_readdata, exp_rd0);
      chk("idle_valid_rd1", r1_readdata, exp_rd1);
      chk("idle_valid_m_read", m_read, 1'b0);

`ifdef DEV_INFO_ARB_TIMEOUT_EN
      // Silent slave: abort after 16 WAIT cycles with the DEAD pattern.
      r1_address = 3'd6;
      r1_read    = 1'b1;
      tick();
      chk("tmo_issue_r1_wr", r1_waitrequest, 1'b0);
      chk("tmo_issue_addr", m_address, 3'd6);
      r1_read = 1'b0;
      tick();
      repeat (15) tick();
      chk("tmo_before_rdv", r1_readdatavalid, 1'b0);
      chk("tmo_before_err", err_timeout, 1'b0);
      tick();
      chk("tmo_rdv1", r1_readdatavalid, 1'b1);
      chk("tmo_rd1", r1_readdata, 32'hDEAD_0006);
      chk("tmo_err", err_timeout, 1'b1);
      chk("tmo_rdv0", r0_readdatavalid, 1'b0);
      m_readdatavalid = 1'b1;
      m_readdata      = 32'h7777_7777;
      tick();
      m_readdatavalid = 1'b0;
      chk("tmo_late_rdv1", r1_readdatavalid, 1'b0);
      chk("tmo_late_rd1", r1_readdata, 32'hDEAD_0006);
      chk("tmo_late_err", err_timeout, 1'b0);
`else
      // Slow slave: 100 cycles of waiting still delivers, with no error.
      r0_address = 3'd1;
      r0_read    = 1'b1;
      tick();
      run_txn("slow_r0", 1'b0, 3'd1, 32'hABCD_0001, 1'b1, 100);
      tick();
      chk("slow_err_after", err_timeout, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
